// File: rtl/scrambler_sequencer_if.sv
// Handshake bundle between the scrambler sequencer and its environment.
// The frame/button/switch inputs come from the board side; the select codes and status go to the video path.
interface scrambler_sequencer_if;
  logic       frame_start;
  logic       btn_mode;
  logic       btn_next;
  logic       apply;
  logic [5:0] sw_manual;
  logic [3:0] swR;
  logic [3:0] swG;
  logic [3:0] swB;
  logic [1:0] mode;
  logic [2:0] preset_idx;
  logic       update_pending;

  modport master (
    output frame_start, btn_mode, btn_next, apply, sw_manual,
    input  swR, swG, swB, mode, preset_idx, update_pending
  );

  modport slave (
    input  frame_start, btn_mode, btn_next, apply, sw_manual,
    output swR, swG, swB, mode, preset_idx, update_pending
  );
endinterface

// File: rtl/scrambler_sequencer.sv
// Generates the per-channel select codes for the colour scrambler. Any change is staged
// and committed only on a frame boundary, so a channel remap never tears mid-frame.
module scrambler_sequencer #(
  parameter int FRAMES_PER_STEP = 60
) (
  input logic                  clk,
  input logic                  rst_n,
  scrambler_sequencer_if.slave bus
);

  localparam int              CW   = $clog2(FRAMES_PER_STEP + 1);
  localparam logic [CW-1:0]   LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_HOLD   = 2'd2
  } mode_e;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } sel_t;

  localparam sel_t IDENTITY = '{r: 2'd0, g: 2'd1, b: 2'd2};

  function automatic sel_t preset(input logic [2:0] idx);
    case (idx)
      3'd0:    return '{r: 2'd0, g: 2'd1, b: 2'd2};
      3'd1:    return '{r: 2'd1, g: 2'd2, b: 2'd0};
      3'd2:    return '{r: 2'd2, g: 2'd0, b: 2'd1};
      3'd3:    return '{r: 2'd0, g: 2'd2, b: 2'd1};
      3'd4:    return '{r: 2'd1, g: 2'd0, b: 2'd2};
      3'd5:    return '{r: 2'd2, g: 2'd1, b: 2'd0};
      3'd6:    return '{r: 2'd0, g: 2'd0, b: 2'd0};
      default: return '{r: 2'd3, g: 2'd3, b: 2'd3};
    endcase
  endfunction

  mode_e         r_mode;
  logic [2:0]    r_idx;
  logic [CW-1:0] r_cnt;
  sel_t          r_staged;
  sel_t          r_out;
  logic          r_pending;
  logic          r_mode_d;
  logic          r_next_d;
  logic          r_apply_d;

  mode_e         w_mode_nx;
  logic [2:0]    w_idx_nx;
  logic [2:0]    w_idx_inc;
  logic [CW-1:0] w_cnt_nx;
  sel_t          w_staged_nx;
  sel_t          w_out_nx;
  logic          w_pending_nx;
  logic          w_mode_ev;
  logic          w_next_ev;
  logic          w_apply_ev;
  logic          w_auto_step;
  logic          w_stage_ev;
  sel_t          w_stage_val;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_mode    <= MODE_MANUAL;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_staged  <= IDENTITY;
      r_out     <= IDENTITY;
      r_pending <= 1'b0;
      r_mode_d  <= 1'b0;
      r_next_d  <= 1'b0;
      r_apply_d <= 1'b0;
    end else begin
      r_mode    <= w_mode_nx;
      r_idx     <= w_idx_nx;
      r_cnt     <= w_cnt_nx;
      r_staged  <= w_staged_nx;
      r_out     <= w_out_nx;
      r_pending <= w_pending_nx;
      r_mode_d  <= bus.btn_mode;
      r_next_d  <= bus.btn_next;
      r_apply_d <= bus.apply;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    w_mode_nx    = r_mode;
    w_idx_nx     = r_idx;
    w_cnt_nx     = r_cnt;
    w_stage_ev   = 1'b0;
    w_stage_val  = r_staged;
    w_idx_inc    = r_idx + 3'd1;

    // A mode press swallows any coincident next/apply press.
    w_mode_ev    = bus.btn_mode & ~r_mode_d;
    w_next_ev    = bus.btn_next & ~r_next_d & ~w_mode_ev;
    w_apply_ev   = bus.apply    & ~r_apply_d & ~w_mode_ev;
    w_auto_step  = (r_mode == MODE_AUTO) && bus.frame_start && (r_cnt == LAST);

    if ((r_mode == MODE_AUTO) && bus.frame_start) begin
      w_cnt_nx = w_auto_step ? '0 : r_cnt + ONE;
    end

    case (r_mode)
      MODE_MANUAL: begin
        if (w_apply_ev) begin
          w_stage_ev  = 1'b1;
          w_stage_val = '{r: bus.sw_manual[1:0], g: bus.sw_manual[3:2], b: bus.sw_manual[5:4]};
        end
      end
      MODE_AUTO, MODE_HOLD: begin
        // A manual step and an auto step in the same cycle advance the index only once.
        if (w_next_ev || w_auto_step) begin
          w_stage_ev  = 1'b1;
          w_idx_nx    = w_idx_inc;
          w_stage_val = preset(w_idx_inc);
        end
      end
      default: ;
    endcase

    if (w_mode_ev) begin
      case (r_mode)
        MODE_MANUAL: begin
          w_mode_nx = MODE_AUTO;
          w_cnt_nx  = '0;
        end
        MODE_AUTO: w_mode_nx = MODE_HOLD;
        default:   w_mode_nx = MODE_MANUAL;
      endcase
    end
  end

  always_comb begin
    w_staged_nx  = w_stage_ev ? w_stage_val : r_staged;
    w_out_nx     = r_out;
    w_pending_nx = r_pending;
    if (bus.frame_start) begin
      if (w_stage_ev) begin
        w_out_nx     = w_stage_val;
        w_pending_nx = 1'b0;
      end else if (r_pending) begin
        w_out_nx     = r_staged;
        w_pending_nx = 1'b0;
      end
    end else if (w_stage_ev) begin
      w_pending_nx = 1'b1;
    end
  end

  assign bus.swR            = {2'b00, r_out.r};
  assign bus.swG            = {2'b00, r_out.g};
  assign bus.swB            = {2'b00, r_out.b};
  assign bus.mode           = r_mode;
  assign bus.preset_idx     = r_idx;
  assign bus.update_pending = r_pending;

endmodule

// File: tb/tb_scrambler_sequencer.sv
// Directed bench for scrambler_sequencer: expected output states are pushed to a scoreboard
// queue as stimulus is applied and popped/compared once the DUT has reacted.
module tb_scrambler_sequencer;

  localparam int FPS = 3;

  logic clk;
  logic rst_n;

  scrambler_sequencer_if bus ();

  scrambler_sequencer #(.FRAMES_PER_STEP(FPS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [1:0] mode;
    logic [2:0] idx;
    logic       pend;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state maintained by the bench.
  logic [3:0] e_r, e_g, e_b;
  logic [1:0] e_mode;
  logic [2:0] e_idx;
  logic       e_pend;

  function automatic logic [11:0] tb_preset(input int i);
    case (i)
      0:       return {4'd0, 4'd1, 4'd2};
      1:       return {4'd1, 4'd2, 4'd0};
      2:       return {4'd2, 4'd0, 4'd1};
      3:       return {4'd0, 4'd2, 4'd1};
      4:       return {4'd1, 4'd0, 4'd2};
      5:       return {4'd2, 4'd1, 4'd0};
      6:       return {4'd0, 4'd0, 4'd0};
      default: return {4'd3, 4'd3, 4'd3};
    endcase
  endfunction

  task automatic set_out_preset(input int i);
    logic [11:0] t;
    t   = tb_preset(i);
    e_r = t[11:8];
    e_g = t[7:4];
    e_b = t[3:0];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.r = e_r; e.g = e_g; e.b = e_b;
    e.mode = e_mode; e.idx = e_idx; e.pend = e_pend;
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".swR"},  32'(bus.swR),            32'(e.r));
      check({tag, ".swG"},  32'(bus.swG),            32'(e.g));
      check({tag, ".swB"},  32'(bus.swB),            32'(e.b));
      check({tag, ".mode"}, 32'(bus.mode),           32'(e.mode));
      check({tag, ".idx"},  32'(bus.preset_idx),     32'(e.idx));
      check({tag, ".pend"}, 32'(bus.update_pending), 32'(e.pend));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1;
    cycle();
    bus.frame_start = 1'b0;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    cycle();
    bus.btn_mode = 1'b0;
    cycle();
  endtask

  task automatic reset_exp();
    e_r = 4'd0; e_g = 4'd1; e_b = 4'd2;
    e_mode = 2'd0; e_idx = 3'd0; e_pend = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.btn_mode    = 1'b0;
    bus.btn_next    = 1'b0;
    bus.apply       = 1'b0;
    bus.sw_manual   = 6'd0;
    reset_exp();
    idle(2);
    rst_n = 1'b1;
    cycle();

    // Reset state and idle frames
    push_exp();
    compare("reset");
    for (int f = 0; f < 5; f++) begin
      frame_pulse();
      push_exp();
      compare("idle_frame");
      idle(3);
    end

    // Manual apply mid-frame: staged, then committed at the next frame
    bus.sw_manual = 6'b00_10_11;
    bus.apply = 1'b1;
    cycle();
    bus.apply = 1'b0;
    e_pend = 1'b1;
    push_exp();
    compare("manual_staged");
    idle(4);
    push_exp();
    compare("manual_wait");
    frame_pulse();
    e_r = 4'd3; e_g = 4'd2; e_b = 4'd0; e_pend = 1'b0;
    push_exp();
    compare("manual_commit");

    // Enter AUTO; 24 frames step every 3rd frame and wrap to 0
    press_mode();
    e_mode = 2'd1;
    push_exp();
    compare("enter_auto");
    for (int f = 1; f <= 24; f++) begin
      frame_pulse();
      if (f % FPS == 0) begin
        e_idx = e_idx + 3'd1;
        set_out_preset(int'(e_idx));
      end
      push_exp();
      compare("auto_frame");
      idle(2);
    end
    check("auto_wrap_idx", 32'(bus.preset_idx), 32'd0);

    // apply is ignored in AUTO
    bus.apply = 1'b1;
    cycle();
    bus.apply = 1'b0;
    cycle();
    push_exp();
    compare("auto_apply_ignored");

    // HOLD: btn_next coincident with frame_start commits on the same edge
    press_mode();
    e_mode = 2'd2;
    push_exp();
    compare("enter_hold");
    bus.btn_next = 1'b1;
    bus.frame_start = 1'b1;
    cycle();
    bus.btn_next = 1'b0;
    bus.frame_start = 1'b0;
    e_idx = 3'd1;
    set_out_preset(1);
    push_exp();
    compare("hold_bypass");
    for (int f = 0; f < 10; f++) begin
      idle(2);
      frame_pulse();
      push_exp();
      compare("hold_frame");
    end

    // Back to AUTO via MANUAL, then mode+next together: mode wins
    press_mode();
    press_mode();
    e_mode = 2'd1;
    push_exp();
    compare("auto_again");
    bus.btn_mode = 1'b1;
    bus.btn_next = 1'b1;
    cycle();
    bus.btn_mode = 1'b0;
    bus.btn_next = 1'b0;
    e_mode = 2'd2;
    push_exp();
    compare("mode_wins");
    cycle();

    // Held btn_next gives exactly one step
    bus.btn_next = 1'b1;
    idle(100);
    bus.btn_next = 1'b0;
    e_idx = 3'd2;
    e_pend = 1'b1;
    push_exp();
    compare("held_next");
    idle(2);
    frame_pulse();
    set_out_preset(2);
    e_pend = 1'b0;
    push_exp();
    compare("held_next_commit");

    // Stage in MANUAL, then async reset discards the pending update
    press_mode();
    e_mode = 2'd0;
    bus.sw_manual = 6'b01_00_11;
    bus.apply = 1'b1;
    cycle();
    bus.apply = 1'b0;
    e_pend = 1'b1;
    push_exp();
    compare("pre_reset_staged");
    #2;
    rst_n = 1'b0;
    #1;
    reset_exp();
    push_exp();
    compare("async_reset");
    cycle();
    rst_n = 1'b1;
    idle(2);
    frame_pulse();
    push_exp();
    compare("post_reset_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
